// File: rtl/dog_extrema_scanner.sv
// Scans a DoG octave stack for strict 26-neighbour extrema passing a contrast threshold.
// Latency per pixel: 9 fetches (row start) or 3 (column step) + READ_LATENCY + 2, plus 1 per keypoint; stalls in EMIT on !kp_ready.
module dog_extrema_scanner #(
    parameter int BIT_DEPTH              = 9,
    parameter int NUM_SCALES             = 4,
    parameter int WIDTH                  = 8,
    parameter int HEIGHT                 = 8,
    parameter int ABS_CONTRAST_THRESHOLD = 4,
    parameter int READ_LATENCY           = 2
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic                              start,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   rd_addr,
    input  logic [NUM_SCALES*BIT_DEPTH-1:0]   rd_data,
    output logic                              kp_valid,
    input  logic                              kp_ready,
    output logic [$clog2(WIDTH)-1:0]          kp_x,
    output logic [$clog2(HEIGHT)-1:0]         kp_y,
    output logic [$clog2(NUM_SCALES)-1:0]     kp_scale,
    output logic                              kp_is_max,
    output logic                              busy,
    output logic                              done,
    output logic [15:0]                       kp_count
);
    localparam int A_W = $clog2(WIDTH*HEIGHT);
    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);
    localparam int S_W = $clog2(NUM_SCALES);
    localparam logic [READ_LATENCY-1:0]   L_LAST = READ_LATENCY'(1) << (READ_LATENCY - 1);
    localparam logic signed [BIT_DEPTH:0] L_THR  = (BIT_DEPTH+1)'(ABS_CONTRAST_THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_ROW, S_FETCH_COL, S_DRAIN, S_EVAL, S_EMIT, S_ADVANCE
    } state_t;

    state_t                        r_state, w_next;
    logic [X_W-1:0]                r_x;
    logic [Y_W-1:0]                r_y;
    logic [1:0]                    r_col, r_row;
    logic [A_W-1:0]                r_last_addr, w_addr;
    logic [READ_LATENCY-1:0]       r_vld;
    logic [1:0]                    r_tc [READ_LATENCY];
    logic [1:0]                    r_tr [READ_LATENCY];
    logic signed [BIT_DEPTH-1:0]   r_win [NUM_SCALES][3][3];
    logic [NUM_SCALES-1:0]         r_mask, r_pol, w_mask, w_pol, w_mask_rest;
    logic                          r_busy, r_done;
    logic [15:0]                   r_count;
    logic                          w_issue, w_hs, w_fetch_last, w_x_more, w_y_more;
    logic signed [BIT_DEPTH-1:0]   w_c;
    logic signed [BIT_DEPTH:0]     w_cx, w_abs;
    logic                          w_gt, w_lt;
    logic [S_W-1:0]                w_sel;
    logic                          w_sel_max;

    assign w_addr       = A_W'((32'(r_y) + 32'(r_row) - 32'd1) * 32'(WIDTH) + 32'(r_x) + 32'(r_col) - 32'd1);
    assign w_fetch_last = (r_row == 2'd2) && (r_col == 2'd2);
    assign w_x_more     = r_x < X_W'(WIDTH - 2);
    assign w_y_more     = r_y < Y_W'(HEIGHT - 2);
    assign w_mask_rest  = r_mask & (r_mask - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:                   if (start) w_next = S_FETCH_ROW;
            S_FETCH_ROW, S_FETCH_COL: if (w_fetch_last) w_next = S_DRAIN;
            S_DRAIN:                  if (r_vld == L_LAST) w_next = S_EVAL;
            S_EVAL:                   w_next = (w_mask != '0) ? S_EMIT : S_ADVANCE;
            S_EMIT:                   if (w_hs && (w_mask_rest == '0)) w_next = S_ADVANCE;
            S_ADVANCE:                w_next = w_x_more ? S_FETCH_COL : (w_y_more ? S_FETCH_ROW : S_IDLE);
            default:                  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue  = (r_state == S_FETCH_ROW) || (r_state == S_FETCH_COL);
        kp_valid = (r_state == S_EMIT);
        w_hs     = kp_valid && kp_ready;
    end

    // Candidate scales only; |centre| widened by one bit so the most-negative sample stays positive.
    always_comb begin
        w_mask = '0;
        w_pol  = '0;
        w_c    = '0;
        w_cx   = '0;
        w_abs  = '0;
        w_gt   = 1'b0;
        w_lt   = 1'b0;
        for (int s = 1; s <= NUM_SCALES - 2; s++) begin
            w_c  = r_win[s][1][1];
            w_gt = 1'b1;
            w_lt = 1'b1;
            for (int d = -1; d <= 1; d++) begin
                for (int c = 0; c < 3; c++) begin
                    for (int r = 0; r < 3; r++) begin
                        if (!(d == 0 && c == 1 && r == 1)) begin
                            if (r_win[s+d][c][r] >= w_c) w_gt = 1'b0;
                            if (r_win[s+d][c][r] <= w_c) w_lt = 1'b0;
                        end
                    end
                end
            end
            w_cx  = {w_c[BIT_DEPTH-1], w_c};
            w_abs = w_cx[BIT_DEPTH] ? -w_cx : w_cx;
            if ((w_gt || w_lt) && (w_abs >= L_THR)) begin
                w_mask[s] = 1'b1;
                w_pol[s]  = w_gt;
            end
        end
    end

    always_comb begin
        w_sel     = '0;
        w_sel_max = 1'b0;
        for (int s = NUM_SCALES - 1; s >= 0; s--) begin
            if (r_mask[s]) begin
                w_sel     = S_W'(s);
                w_sel_max = r_pol[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_x         <= '0;
            r_y         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_last_addr <= '0;
            r_vld       <= '0;
            r_mask      <= '0;
            r_pol       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tc[i] <= '0;
                r_tr[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_issue) begin
                r_last_addr <= w_addr;
                if (r_row == 2'd2) begin
                    r_row <= '0;
                    r_col <= r_col + 2'd1;
                end else begin
                    r_row <= r_row + 2'd1;
                end
            end
            // Tags travel with each read so captures land in the right window slot.
            r_vld   <= (r_vld << 1) | READ_LATENCY'(w_issue);
            r_tc[0] <= r_col;
            r_tr[0] <= r_row;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tc[i] <= r_tc[i-1];
                r_tr[i] <= r_tr[i-1];
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_busy  <= 1'b1;
                    r_count <= '0;
                    r_x     <= X_W'(1);
                    r_y     <= Y_W'(1);
                    r_col   <= '0;
                    r_row   <= '0;
                end
                S_EVAL: begin
                    r_mask <= w_mask;
                    r_pol  <= w_pol;
                end
                S_EMIT: if (w_hs) begin
                    r_mask <= w_mask_rest;
                    if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                end
                S_ADVANCE: begin
                    r_row <= '0;
                    if (w_x_more) begin
                        r_x   <= r_x + X_W'(1);
                        r_col <= 2'd2;
                    end else if (w_y_more) begin
                        r_x   <= X_W'(1);
                        r_y   <= r_y + Y_W'(1);
                        r_col <= '0;
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_FETCH_COL && r_row == 2'd0) begin
            for (int s = 0; s < NUM_SCALES; s++) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[s][0][r] <= r_win[s][1][r];
                    r_win[s][1][r] <= r_win[s][2][r];
                end
            end
        end
        if (r_vld[READ_LATENCY-1]) begin
            for (int s = 0; s < NUM_SCALES; s++)
                r_win[s][r_tc[READ_LATENCY-1]][r_tr[READ_LATENCY-1]] <= rd_data[s*BIT_DEPTH +: BIT_DEPTH];
        end
    end

    assign rd_addr   = w_issue ? w_addr : r_last_addr;
    assign kp_x      = r_x;
    assign kp_y      = r_y;
    assign kp_scale  = w_sel;
    assign kp_is_max = w_sel_max;
    assign busy      = r_busy;
    assign done      = r_done;
    assign kp_count  = r_count;
endmodule

// File: tb/tb_dog_extrema_scanner.sv
// Three scanners (read latency 1, 2, 3) on a 5x5x4 frame, checked against a direct extremum model.
module tb_dog_extrema_scanner;
    localparam int BD = 9, NS = 4, W = 5, H = 5, THR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [2:0]               start_v, rdy_v, kp_valid_v, kp_is_max_v, busy_v, done_v;
    logic [2:0][4:0]          rd_addr_v;
    logic [2:0][NS*BD-1:0]    rd_data_v;
    logic [2:0][2:0]          kp_x_v, kp_y_v;
    logic [2:0][1:0]          kp_scale_v;
    logic [2:0][15:0]         kp_count_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dog_extrema_scanner #(
            .BIT_DEPTH(BD), .NUM_SCALES(NS), .WIDTH(W), .HEIGHT(H),
            .ABS_CONTRAST_THRESHOLD(THR), .READ_LATENCY(g + 1)
        ) u_dut (
            .clk(clk), .rst_in(rst_n), .start(start_v[g]),
            .rd_addr(rd_addr_v[g]), .rd_data(rd_data_v[g]),
            .kp_valid(kp_valid_v[g]), .kp_ready(rdy_v[g]),
            .kp_x(kp_x_v[g]), .kp_y(kp_y_v[g]), .kp_scale(kp_scale_v[g]),
            .kp_is_max(kp_is_max_v[g]), .busy(busy_v[g]), .done(done_v[g]),
            .kp_count(kp_count_v[g])
        );
    end

    int mem [NS][H][W];
    int pipe [3][3];
    int ex_x [16], ex_y [16], ex_s [16], ex_m [16];
    int exp_n;
    int idx [3];
    int busy_cyc [3];
    logic prev_v [3];
    int n_cmp = 0, n_bad = 0;

    // BRAM: data in cycle t+L belongs to the address presented in cycle t.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            pipe[g][0] <= int'(rd_addr_v[g]);
            for (int k = 1; k < 3; k++) pipe[g][k] <= pipe[g][k-1];
        end
    end

    always_comb begin
        rd_data_v = '0;
        for (int g = 0; g < 3; g++)
            for (int s = 0; s < NS; s++)
                rd_data_v[g][s*BD +: BD] = BD'(mem[s][pipe[g][g] / W][pipe[g][g] % W]);
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic clear_mem();
        for (int s = 0; s < NS; s++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) mem[s][y][x] = 0;
    endtask

    task automatic build_model();
        int c, n, a;
        bit gt, lt;
        exp_n = 0;
        for (int y = 1; y <= H - 2; y++)
            for (int x = 1; x <= W - 2; x++)
                for (int s = 1; s <= NS - 2; s++) begin
                    c = mem[s][y][x];
                    gt = 1; lt = 1;
                    for (int ds = -1; ds <= 1; ds++)
                        for (int dy = -1; dy <= 1; dy++)
                            for (int dx = -1; dx <= 1; dx++)
                                if (ds != 0 || dy != 0 || dx != 0) begin
                                    n = mem[s+ds][y+dy][x+dx];
                                    if (n >= c) gt = 0;
                                    if (n <= c) lt = 0;
                                end
                    a = (c < 0) ? -c : c;
                    if ((gt || lt) && a >= THR) begin
                        ex_x[exp_n] = x; ex_y[exp_n] = y; ex_s[exp_n] = s; ex_m[exp_n] = int'(gt);
                        exp_n++;
                    end
                end
    endtask

    // Every valid cycle is checked against the model, so stalled keypoints must hold steady.
    initial begin
        for (int g = 0; g < 3; g++) begin prev_v[g] = 1'b0; idx[g] = 0; busy_cyc[g] = 0; end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (busy_v[g]) busy_cyc[g]++;
                if (rst_n && prev_v[g] && rdy_v[g]) begin
                    idx[g]++;
                    chk($sformatf("L%0d kp_count", g + 1), int'(kp_count_v[g]), idx[g]);
                end
                if (kp_valid_v[g]) begin
                    if (idx[g] < exp_n) begin
                        chk($sformatf("L%0d kp_x", g + 1), int'(kp_x_v[g]), ex_x[idx[g]]);
                        chk($sformatf("L%0d kp_y", g + 1), int'(kp_y_v[g]), ex_y[idx[g]]);
                        chk($sformatf("L%0d kp_scale", g + 1), int'(kp_scale_v[g]), ex_s[idx[g]]);
                        chk($sformatf("L%0d kp_is_max", g + 1), int'(kp_is_max_v[g]), ex_m[idx[g]]);
                    end else begin
                        n_cmp++; n_bad++;
                        $display("FAIL L%0d extra keypoint: got x=%0d y=%0d s=%0d, expected none",
                                 g + 1, kp_x_v[g], kp_y_v[g], kp_scale_v[g]);
                    end
                end
                prev_v[g] = kp_valid_v[g];
            end
        end
    end

    task automatic run_scan(input int g, input int stall, input bit extra);
        int stl, lat, exp_busy;
        bit got_done;
        idx[g] = 0; busy_cyc[g] = 0; stl = stall; got_done = 0; lat = g + 1;
        @(negedge clk); #1;
        start_v[g] = 1'b1;
        for (int c = 0; c < 600 && !got_done; c++) begin
            @(negedge clk); #1;
            start_v[g] = extra && (c == 15);
            if (done_v[g]) got_done = 1;
            if (kp_valid_v[g] && stl > 0) begin rdy_v[g] = 1'b0; stl--; end
            else rdy_v[g] = 1'b1;
        end
        start_v[g] = 1'b0;
        rdy_v[g] = 1'b1;
        exp_busy = (H - 2) * ((9 + lat + 2) + (W - 3) * (3 + lat + 2)) + exp_n + stall;
        chk($sformatf("L%0d done seen", lat), int'(got_done), 1);
        chk($sformatf("L%0d busy cycles", lat), busy_cyc[g], exp_busy);
        chk($sformatf("L%0d final kp_count", lat), int'(kp_count_v[g]), exp_n);
        chk($sformatf("L%0d keypoints accepted", lat), idx[g], exp_n);
        chk($sformatf("L%0d kp_valid after done", lat), int'(kp_valid_v[g]), 0);
        repeat (3) @(negedge clk);
        chk($sformatf("L%0d busy idle", lat), int'(busy_v[g]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; start_v = '0; rdy_v = '1;
        clear_mem();
        build_model();
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst busy", int'(busy_v[g]), 0);
            chk("rst done", int'(done_v[g]), 0);
            chk("rst kp_valid", int'(kp_valid_v[g]), 0);
            chk("rst rd_addr", int'(rd_addr_v[g]), 0);
            chk("rst kp_x", int'(kp_x_v[g]), 0);
            chk("rst kp_y", int'(kp_y_v[g]), 0);
            chk("rst kp_scale", int'(kp_scale_v[g]), 0);
            chk("rst kp_is_max", int'(kp_is_max_v[g]), 0);
            chk("rst kp_count", int'(kp_count_v[g]), 0);
        end
        #1 rst_n = 1'b1;

        // Single peak
        mem[1][2][2] = 50;
        build_model();
        chk("model s1 count", exp_n, 1);
        chk("model s1 x", ex_x[0], 2);
        chk("model s1 y", ex_y[0], 2);
        chk("model s1 scale", ex_s[0], 1);
        chk("model s1 is_max", ex_m[0], 1);
        run_scan(1, 0, 0);
        chk("L2 single-peak busy literal", busy_cyc[1], 82);

        // Contrast threshold boundary
        mem[1][2][2] = 3;
        build_model();
        chk("model thr3 count", exp_n, 0);
        run_scan(1, 0, 0);
        mem[1][2][2] = 4;
        build_model();
        chk("model thr4 count", exp_n, 1);
        run_scan(1, 0, 0);

        // Cross-scale tie
        mem[1][2][2] = 50;
        mem[2][3][3] = 50;
        build_model();
        chk("model tie count", exp_n, 0);
        run_scan(1, 0, 0);

        // Two keypoints at one pixel, first one stalled
        clear_mem();
        mem[1][2][2] = -60;
        mem[2][2][2] = 60;
        build_model();
        chk("model pair count", exp_n, 2);
        chk("model pair scale0", ex_s[0], 1);
        chk("model pair max0", ex_m[0], 0);
        chk("model pair scale1", ex_s[1], 2);
        chk("model pair max1", ex_m[1], 1);
        run_scan(1, 5, 0);

        // Reset while the second keypoint is pending
        idx[1] = 0;
        rdy_v[1] = 1'b0;
        @(negedge clk); #1 start_v[1] = 1'b1;
        @(negedge clk); #1 start_v[1] = 1'b0;
        seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk); #1;
            if (kp_valid_v[1]) seen = 1;
        end
        chk("midscan kp_valid reached", int'(seen), 1);
        rdy_v[1] = 1'b1;
        @(negedge clk); #1;
        rdy_v[1] = 1'b0;
        chk("midscan count before reset", int'(kp_count_v[1]), 1);
        chk("midscan busy before reset", int'(busy_v[1]), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midscan rst busy", int'(busy_v[1]), 0);
        chk("midscan rst kp_valid", int'(kp_valid_v[1]), 0);
        chk("midscan rst kp_count", int'(kp_count_v[1]), 0);
        chk("midscan rst rd_addr", int'(rd_addr_v[1]), 0);
        #1 rst_n = 1'b1;
        rdy_v[1] = 1'b1;

        // Fresh scans across read latencies, with a stray start mid-scan
        clear_mem();
        mem[1][2][2] = 50;
        build_model();
        run_scan(1, 0, 0);
        run_scan(0, 0, 1);
        run_scan(2, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
